bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the CPU fetch/data requesters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        flush_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic [5:0]  stall_o;
  logic        err_o;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
           flush_i, bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_ack_o, d_rdata_o, d_ack_o, bus_req_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
           flush_i, bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_ack_o, d_rdata_o, d_ack_o, bus_req_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/bus_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port, with data priority,
// a wait-cycle timeout, fetch cancellation on pipeline flush and a pipeline stall vector.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  port
);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        grant_data;
  logic        grant_fetch;
  logic        finish;
  logic        timeout;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;
  logic        owner_data;
  logic        timed_out;
  logic        cancel;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        resp;
  logic        if_ack;
  logic        d_ack;

  assign wait_next = wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // An ack wins over a timeout landing in the same cycle.
  always_comb begin
    next_state  = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    finish      = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (port.d_req_i) begin
          next_state = DBUSY;
          grant_data = 1'b1;
        end else if (port.if_req_i) begin
          next_state  = IBUSY;
          grant_fetch = 1'b1;
        end
      end
      IBUSY, DBUSY: begin
        if (port.bus_ack_i) begin
          next_state = RESP;
          finish     = 1'b1;
        end else if (wait_next == WAIT_LAST) begin
          next_state = RESP;
          timeout    = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= 4'h0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      wait_cnt   <= 8'h0;
      owner_data <= 1'b0;
      timed_out  <= 1'b0;
      rdata      <= 32'h0;
    end else begin
      if (grant_data) begin
        bus_req    <= 1'b1;
        bus_we     <= port.d_we_i;
        bus_sel    <= port.d_sel_i;
        bus_addr   <= port.d_addr_i;
        bus_wdata  <= port.d_wdata_i;
        wait_cnt   <= 8'h0;
        owner_data <= 1'b1;
        timed_out  <= 1'b0;
      end else if (grant_fetch) begin
        bus_req    <= 1'b1;
        bus_we     <= 1'b0;
        bus_sel    <= 4'hF;
        bus_addr   <= port.if_addr_i;
        bus_wdata  <= 32'h0;
        wait_cnt   <= 8'h0;
        owner_data <= 1'b0;
        timed_out  <= 1'b0;
      end else if (finish) begin
        bus_req <= 1'b0;
        rdata   <= port.bus_rdata_i;
      end else if (timeout) begin
        bus_req   <= 1'b0;
        rdata     <= 32'h0;
        timed_out <= 1'b1;
      end else if (state == IBUSY || state == DBUSY) begin
        wait_cnt <= wait_next;
      end
    end
  end

  // A flushed fetch still finishes on the bus so the memory side stays consistent.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE)                cancel <= 1'b0;
    else if (state == IBUSY && port.flush_i) cancel <= 1'b1;
  end

  assign resp   = (state == RESP);
  assign if_ack = resp && !owner_data && !cancel && !port.flush_i;
  assign d_ack  = resp && owner_data;

  assign port.if_ack_o    = if_ack;
  assign port.d_ack_o     = d_ack;
  assign port.if_rdata_o  = if_ack ? rdata : 32'h0;
  assign port.d_rdata_o   = d_ack ? rdata : 32'h0;
  assign port.err_o       = resp && timed_out;
  assign port.bus_req_o   = bus_req;
  assign port.bus_we_o    = bus_we;
  assign port.bus_sel_o   = bus_sel;
  assign port.bus_addr_o  = bus_addr;
  assign port.bus_wdata_o = bus_wdata;

  always_comb begin
    port.stall_o = 6'b000000;
    if (!rst) begin
      if (port.d_req_i && !d_ack)        port.stall_o = 6'b011111;
      else if (port.if_req_i && !if_ack) port.stall_o = 6'b000111;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a default-timeout instance for normal traffic and a
// TIMEOUT=4 instance for the abandoned-transaction case.
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  bus_arbiter_if bif();
  bus_arbiter_if tif();

  bus_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .port (bif)
  );

  bus_arbiter #(.TIMEOUT(4)) dut_to (
    .clk  (clk),
    .rst  (rst),
    .port (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.if_req_i = 0; bif.if_addr_i = 0; bif.d_req_i = 0; bif.d_we_i = 0;
    bif.d_sel_i = 0; bif.d_addr_i = 0; bif.d_wdata_i = 0; bif.flush_i = 0;
    bif.bus_rdata_i = 0; bif.bus_ack_i = 0;
    tif.if_req_i = 0; tif.if_addr_i = 0; tif.d_req_i = 0; tif.d_we_i = 0;
    tif.d_sel_i = 0; tif.d_addr_i = 0; tif.d_wdata_i = 0; tif.flush_i = 0;
    tif.bus_rdata_i = 0; tif.bus_ack_i = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    next_cycle();
    next_cycle();
    bif.d_req_i = 1;
    #2;
    tests++; if (bif.stall_o !== 6'b0) begin failed++; $display("[TB] FAIL reset_stall got %b want %b", bif.stall_o, 6'b0); end
    tests++; if (bif.bus_req_o !== 1'b0) begin failed++; $display("[TB] FAIL reset_bus_req got %b want 0", bif.bus_req_o); end
    tests++; if ({bif.if_ack_o, bif.d_ack_o, bif.err_o} !== 3'b000) begin failed++; $display("[TB] FAIL reset_acks got %b want 000", {bif.if_ack_o, bif.d_ack_o, bif.err_o}); end
    tests++; if (bif.bus_addr_o !== 32'h0) begin failed++; $display("[TB] FAIL reset_bus_addr got %h want 0", bif.bus_addr_o); end
    next_cycle();
    bif.d_req_i = 0;
    rst = 0;
  endtask

  task automatic test_fetch();
    next_cycle();
    bif.if_req_i = 1; bif.if_addr_i = 32'h100;
    #2;
    tests++; if (bif.stall_o !== 6'b000111) begin failed++; $display("[TB] FAIL fetch_stall_n got %b want 000111", bif.stall_o); end
    tests++; if (bif.bus_req_o !== 1'b0) begin failed++; $display("[TB] FAIL fetch_req_n got %b want 0", bif.bus_req_o); end
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h3402_0001;
    #2;
    tests++; if (bif.bus_req_o !== 1'b1) begin failed++; $display("[TB] FAIL fetch_req_n1 got %b want 1", bif.bus_req_o); end
    tests++; if ({bif.bus_addr_o, bif.bus_sel_o, bif.bus_we_o} !== {32'h100, 4'hF, 1'b0}) begin failed++; $display("[TB] FAIL fetch_bus got %h/%h/%b want 100/f/0", bif.bus_addr_o, bif.bus_sel_o, bif.bus_we_o); end
    tests++; if (bif.bus_wdata_o !== 32'h0) begin failed++; $display("[TB] FAIL fetch_wdata got %h want 0", bif.bus_wdata_o); end
    tests++; if (bif.stall_o !== 6'b000111) begin failed++; $display("[TB] FAIL fetch_stall_n1 got %b want 000111", bif.stall_o); end
    next_cycle();
    bif.bus_ack_i = 0; bif.bus_rdata_i = 32'hFFFF_0000;
    #2;
    tests++; if (bif.if_ack_o !== 1'b1) begin failed++; $display("[TB] FAIL fetch_ack got %b want 1", bif.if_ack_o); end
    tests++; if (bif.if_rdata_o !== 32'h3402_0001) begin failed++; $display("[TB] FAIL fetch_rdata got %h want 34020001", bif.if_rdata_o); end
    tests++; if (bif.bus_req_o !== 1'b0) begin failed++; $display("[TB] FAIL fetch_req_drop got %b want 0", bif.bus_req_o); end
    tests++; if (bif.stall_o !== 6'b0) begin failed++; $display("[TB] FAIL fetch_stall_ack got %b want 0", bif.stall_o); end
    next_cycle();
    bif.if_req_i = 0;
    #2;
    tests++; if ({bif.if_ack_o, bif.if_rdata_o} !== 33'h0) begin failed++; $display("[TB] FAIL fetch_ack_pulse got %b/%h want 0/0", bif.if_ack_o, bif.if_rdata_o); end
  endtask

  task automatic test_priority();
    next_cycle();
    bif.if_req_i = 1; bif.if_addr_i = 32'h104;
    bif.d_req_i = 1; bif.d_we_i = 0; bif.d_sel_i = 4'hF; bif.d_addr_i = 32'h200;
    #2;
    tests++; if (bif.stall_o !== 6'b011111) begin failed++; $display("[TB] FAIL prio_stall_n got %b want 011111", bif.stall_o); end
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'hAAAA_5555;
    #2;
    tests++; if ({bif.bus_req_o, bif.bus_addr_o, bif.bus_we_o} !== {1'b1, 32'h200, 1'b0}) begin failed++; $display("[TB] FAIL prio_data_grant got %b/%h/%b want 1/200/0", bif.bus_req_o, bif.bus_addr_o, bif.bus_we_o); end
    tests++; if (bif.stall_o !== 6'b011111) begin failed++; $display("[TB] FAIL prio_stall_busy got %b want 011111", bif.stall_o); end
    next_cycle();
    bif.bus_ack_i = 0; bif.bus_rdata_i = 32'h0;
    #2;
    tests++; if ({bif.d_ack_o, bif.d_rdata_o, bif.if_ack_o} !== {1'b1, 32'hAAAA_5555, 1'b0}) begin failed++; $display("[TB] FAIL prio_d_ack got %b/%h/%b want 1/aaaa5555/0", bif.d_ack_o, bif.d_rdata_o, bif.if_ack_o); end
    tests++; if (bif.stall_o !== 6'b000111) begin failed++; $display("[TB] FAIL prio_stall_resp got %b want 000111", bif.stall_o); end
    next_cycle();
    bif.d_req_i = 0;
    #2;
    tests++; if ({bif.bus_req_o, bif.d_ack_o} !== 2'b00) begin failed++; $display("[TB] FAIL prio_idle got %b want 00", {bif.bus_req_o, bif.d_ack_o}); end
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_1234;
    #2;
    tests++; if ({bif.bus_req_o, bif.bus_addr_o, bif.bus_sel_o} !== {1'b1, 32'h104, 4'hF}) begin failed++; $display("[TB] FAIL prio_fetch_grant got %b/%h/%h want 1/104/f", bif.bus_req_o, bif.bus_addr_o, bif.bus_sel_o); end
    next_cycle();
    bif.bus_ack_i = 0;
    #2;
    tests++; if ({bif.if_ack_o, bif.if_rdata_o} !== {1'b1, 32'h0000_1234}) begin failed++; $display("[TB] FAIL prio_fetch_ack got %b/%h want 1/00001234", bif.if_ack_o, bif.if_rdata_o); end
    next_cycle();
    bif.if_req_i = 0;
  endtask

  task automatic test_store();
    next_cycle();
    bif.d_req_i = 1; bif.d_we_i = 1; bif.d_sel_i = 4'b0011;
    bif.d_addr_i = 32'h300; bif.d_wdata_i = 32'hDEAD_BEEF;
    next_cycle();
    bif.d_wdata_i = 32'h0; bif.d_sel_i = 4'hF; bif.d_we_i = 0; bif.d_addr_i = 32'h0;
    #2;
    tests++; if ({bif.bus_we_o, bif.bus_sel_o, bif.bus_wdata_o} !== {1'b1, 4'b0011, 32'hDEAD_BEEF}) begin failed++; $display("[TB] FAIL store_bus got %b/%b/%h want 1/0011/deadbeef", bif.bus_we_o, bif.bus_sel_o, bif.bus_wdata_o); end
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_00AB;
    #2;
    tests++; if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_wdata_o, bif.bus_addr_o} !== {1'b1, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h300}) begin failed++; $display("[TB] FAIL store_stable got %b/%b/%b/%h/%h want 1/1/0011/deadbeef/300", bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_wdata_o, bif.bus_addr_o); end
    next_cycle();
    bif.bus_ack_i = 0;
    #2;
    tests++; if ({bif.d_ack_o, bif.bus_req_o} !== 2'b10) begin failed++; $display("[TB] FAIL store_ack got %b want 10", {bif.d_ack_o, bif.bus_req_o}); end
    next_cycle();
    bif.d_req_i = 0;
  endtask

  task automatic test_flush();
    next_cycle();
    bif.if_req_i = 1; bif.if_addr_i = 32'h180;
    next_cycle();
    bif.flush_i = 1; bif.if_req_i = 0;
    next_cycle();
    bif.flush_i = 0;
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_0005;
    next_cycle();
    bif.bus_ack_i = 0;
    #2;
    tests++; if ({bif.if_ack_o, bif.if_rdata_o, bif.bus_req_o} !== 34'h0) begin failed++; $display("[TB] FAIL flush_no_ack got %b/%h/%b want 0/0/0", bif.if_ack_o, bif.if_rdata_o, bif.bus_req_o); end
    next_cycle();
    bif.if_req_i = 1; bif.if_addr_i = 32'h1C0;
    #2;
    tests++; if (bif.if_ack_o !== 1'b0) begin failed++; $display("[TB] FAIL flush_idle_ack got %b want 0", bif.if_ack_o); end
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_0077;
    #2;
    tests++; if ({bif.bus_req_o, bif.bus_addr_o} !== {1'b1, 32'h1C0}) begin failed++; $display("[TB] FAIL flush_next_grant got %b/%h want 1/1c0", bif.bus_req_o, bif.bus_addr_o); end
    next_cycle();
    bif.bus_ack_i = 0;
    #2;
    tests++; if ({bif.if_ack_o, bif.if_rdata_o} !== {1'b1, 32'h0000_0077}) begin failed++; $display("[TB] FAIL flush_next_ack got %b/%h want 1/00000077", bif.if_ack_o, bif.if_rdata_o); end
    next_cycle();
    bif.if_req_i = 0;
  endtask

  task automatic test_flush_resp();
    next_cycle();
    bif.if_req_i = 1; bif.if_addr_i = 32'h2C0;
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h0000_0099;
    next_cycle();
    bif.bus_ack_i = 0; bif.flush_i = 1; bif.if_req_i = 0;
    #2;
    tests++; if ({bif.if_ack_o, bif.if_rdata_o} !== 33'h0) begin failed++; $display("[TB] FAIL flush_resp got %b/%h want 0/0", bif.if_ack_o, bif.if_rdata_o); end
    next_cycle();
    bif.flush_i = 0;
  endtask

  task automatic test_timeout();
    next_cycle();
    tif.d_req_i = 1; tif.d_addr_i = 32'h400; tif.d_sel_i = 4'hF; tif.bus_rdata_i = 32'hFFFF_FFFF;
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      #2;
      tests++; if ({tif.bus_req_o, tif.d_ack_o, tif.err_o} !== 3'b100) begin failed++; $display("[TB] FAIL timeout_busy%0d got %b want 100", i, {tif.bus_req_o, tif.d_ack_o, tif.err_o}); end
    end
    next_cycle();
    #2;
    tests++; if ({tif.bus_req_o, tif.d_ack_o, tif.err_o} !== 3'b011) begin failed++; $display("[TB] FAIL timeout_resp got %b want 011", {tif.bus_req_o, tif.d_ack_o, tif.err_o}); end
    tests++; if (tif.d_rdata_o !== 32'h0) begin failed++; $display("[TB] FAIL timeout_rdata got %h want 0", tif.d_rdata_o); end
    next_cycle();
    tif.d_req_i = 0;
    #2;
    tests++; if ({tif.d_ack_o, tif.err_o} !== 2'b00) begin failed++; $display("[TB] FAIL timeout_pulse got %b want 00", {tif.d_ack_o, tif.err_o}); end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bif.d_req_i = 1; bif.d_we_i = 0; bif.d_addr_i = 32'h500; bif.d_sel_i = 4'hF;
    next_cycle();
    rst = 1;
    next_cycle();
    bif.bus_ack_i = 1; bif.bus_rdata_i = 32'h1111_2222;
    #2;
    tests++; if ({bif.bus_req_o, bif.bus_addr_o, bif.d_ack_o, bif.stall_o, bif.err_o} !== 40'h0) begin failed++; $display("[TB] FAIL rstmid_outputs got %b/%h/%b/%b/%b want all 0", bif.bus_req_o, bif.bus_addr_o, bif.d_ack_o, bif.stall_o, bif.err_o); end
    next_cycle();
    rst = 0; bif.d_req_i = 0;
    #2;
    tests++; if ({bif.bus_req_o, bif.d_ack_o, bif.d_rdata_o} !== 34'h0) begin failed++; $display("[TB] FAIL rstmid_after got %b/%b/%h want 0/0/0", bif.bus_req_o, bif.d_ack_o, bif.d_rdata_o); end
    next_cycle();
    #2;
    tests++; if ({bif.bus_req_o, bif.d_ack_o, bif.if_ack_o} !== 3'b000) begin failed++; $display("[TB] FAIL rstmid_stray_ack got %b want 000", {bif.bus_req_o, bif.d_ack_o, bif.if_ack_o}); end
    next_cycle();
    bif.bus_ack_i = 0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_flush();
    test_flush_resp();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
